// File: rtl/i2c_master_xfer.sv
// i2c_master_xfer: single-transaction I2C master.
// Per command: START, {addr,rw}, 0..MAX_LEN data bytes, STOP.
// Ports:
//   clk, rst_n                     system clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_addr, cmd_rw, cmd_len      slave address, 0=write/1=read, byte count
//   wr_data/wr_req                 write byte source, captured while wr_req=1
//   rd_data/rd_valid               received byte with 1-cycle strobe
//   busy, done, nack, start, stop  transaction status and event pulses
//   scl_oe, sda_oe                 open-drain pulls (1 = drive low)
//   sda_i                          sampled SDA pad level
module i2c_master_xfer #(
    parameter int unsigned CLK_DIV = 125,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             start,
    output logic             stop,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_i
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] byte_q, byte_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       sh_q, sh_d;
    logic             rw_q, rw_d;
    logic             nflag_q, nflag_d;

    logic             cmd_ready_d, wr_req_d, rd_valid_d, busy_d;
    logic             done_d, nack_d, start_d, stop_d, scl_d, sda_d;
    logic [7:0]       rd_data_d;

    logic             tick;
    logic             last_byte;

    assign tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign last_byte = (byte_q == (len_q - LEN_W'(1)));

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            len_q     <= '0;
            sh_q      <= '0;
            rw_q      <= 1'b0;
            nflag_q   <= 1'b0;
            cmd_ready <= 1'b1;
            wr_req    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            len_q     <= len_d;
            sh_q      <= sh_d;
            rw_q      <= rw_d;
            nflag_q   <= nflag_d;
            cmd_ready <= cmd_ready_d;
            wr_req    <= wr_req_d;
            rd_data   <= rd_data_d;
            rd_valid  <= rd_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            nack      <= nack_d;
            start     <= start_d;
            stop      <= stop_d;
            scl_oe    <= scl_d;
            sda_oe    <= sda_d;
        end
    end

    // Next-state and next-output logic; one bit = Q0 low, Q1/Q2 high, Q3 low
    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        sh_d       = sh_q;
        rw_d       = rw_q;
        nflag_d    = nflag_q;
        wr_req_d   = 1'b0;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        nack_d     = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        scl_d      = scl_oe;
        sda_d      = sda_oe;

        // Write byte arrives in the wr_req cycle; SCL is still low in Q0
        if (wr_req) begin
            sh_d  = wr_data;
            sda_d = ~wr_data[7];
        end

        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (cmd_valid) begin
                    state_d = S_START;
                    qtr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    len_d   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    sh_d    = {cmd_addr, cmd_rw};
                    rw_d    = cmd_rw;
                    nflag_d = 1'b0;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    sda_d   = 1'b1;
                    scl_d   = 1'b0;
                end
            end

            // SDA low with SCL high for two quarters, then one quarter SCL low
            S_START: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd1) begin
                        scl_d = 1'b1;
                    end
                    if (qtr_q == 2'd2) begin
                        state_d = S_ADDR;
                        qtr_d   = '0;
                        sda_d   = ~sh_q[7];
                    end
                end
            end

            S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    unique case (qtr_q)
                        2'd0: scl_d = 1'b0;
                        2'd2: scl_d = 1'b1;
                        2'd1: begin
                            if ((state_q == S_AACK) || (state_q == S_WACK)) begin
                                if (sda_i) begin
                                    nflag_d = 1'b1;
                                end
                            end else if (state_q == S_RD) begin
                                sh_d = {sh_q[6:0], sda_i};
                                if (bit_q == 3'd7) begin
                                    rd_data_d  = {sh_q[6:0], sda_i};
                                    rd_valid_d = 1'b1;
                                end
                            end
                        end
                        default: begin
                            // End of Q3: choose the next bit and set SDA for its Q0
                            unique case (state_q)
                                S_ADDR, S_WR: begin
                                    if (bit_q == 3'd7) begin
                                        state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                                        bit_d   = '0;
                                        sda_d   = 1'b0;
                                    end else begin
                                        bit_d = bit_q + 3'd1;
                                        sh_d  = {sh_q[6:0], 1'b0};
                                        sda_d = ~sh_q[6];
                                    end
                                end
                                S_AACK: begin
                                    if (nflag_q || (len_q == '0)) begin
                                        state_d = S_STOP;
                                        sda_d   = 1'b1;
                                    end else if (rw_q) begin
                                        state_d = S_RD;
                                        sda_d   = 1'b0;
                                    end else begin
                                        state_d  = S_WR;
                                        wr_req_d = 1'b1;
                                    end
                                end
                                S_WACK: begin
                                    if (nflag_q || last_byte) begin
                                        state_d = S_STOP;
                                        sda_d   = 1'b1;
                                    end else begin
                                        state_d  = S_WR;
                                        byte_d   = byte_q + LEN_W'(1);
                                        wr_req_d = 1'b1;
                                    end
                                end
                                S_RD: begin
                                    if (bit_q == 3'd7) begin
                                        state_d = S_MACK;
                                        bit_d   = '0;
                                        // ACK every byte but the last
                                        sda_d   = ~last_byte;
                                    end else begin
                                        bit_d = bit_q + 3'd1;
                                    end
                                end
                                S_MACK: begin
                                    if (last_byte) begin
                                        state_d = S_STOP;
                                        sda_d   = 1'b1;
                                    end else begin
                                        state_d = S_RD;
                                        byte_d  = byte_q + LEN_W'(1);
                                        sda_d   = 1'b0;
                                    end
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    endcase
                end
            end

            // SDA low/SCL low, release SCL, one quarter later release SDA
            S_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd0) begin
                        scl_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        qtr_d   = '0;
                        sda_d   = 1'b0;
                        stop_d  = 1'b1;
                        done_d  = 1'b1;
                        nack_d  = nflag_q;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_i2c_master_xfer.sv
`timescale 1ns/1ps
module tb_i2c_master_xfer;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned LEN_W    = 5;
    localparam int          BIT_CLKS = 4 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [6:0]       cmd_addr = '0;
    logic             cmd_rw = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       wr_data;
    logic             wr_req;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy, done, nack, start, stop;
    logic             scl_oe, sda_oe, sda_i;
    logic             slave_pull = 1'b0;

    logic [7:0]       tx_data [0:31];
    logic [4:0]       wr_idx = '0;

    assign sda_i   = ~(sda_oe | slave_pull);
    assign wr_data = tx_data[wr_idx];

    i2c_master_xfer #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .nack(nack), .start(start), .stop(stop),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor / slave state
    logic       mon_on = 1'b0;
    logic       high_seen = 1'b0;
    logic       hbit = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       wr_pend = 1'b0;
    int         nbits = 0;
    int         cyc = 0;
    int         last_rise = -1;
    int         starts = 0, stops = 0, period_err = 0, sda_err = 0, wr_cnt = 0;
    logic       bus_bits [$];
    logic [7:0] rd_q [$];
    logic       sl_addr_ack = 1'b1;
    logic       sl_rw = 1'b0;
    int         sl_len = 0;
    int         sl_nack_byte = 99;

    // Expectations from the reference model
    logic       exp_bits [$];
    int         exp_nack, exp_wr, exp_rd;

    // Slave's SDA pull for bus bit n (9 bits per byte incl. ack)
    function automatic logic slave_bit(input int n);
        int k, j;
        if (n == 8) return sl_addr_ack;
        if (n < 9 || !sl_addr_ack) return 1'b0;
        k = (n - 9) / 9;
        j = (n - 9) % 9;
        if (k >= sl_len) return 1'b0;
        if (!sl_rw) return (j == 8) && (k != sl_nack_byte);
        if (j < 8) return ~tx_data[k][7 - j];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic scl_l, sda_l;
        cyc++;
        scl_l = ~scl_oe;
        sda_l = sda_i;
        if (!rst_n) begin
            mon_on     = 1'b0;
            high_seen  = 1'b0;
            slave_pull = 1'b0;
            wr_pend    = 1'b0;
        end else begin
            if (wr_req) begin
                wr_cnt++;
                wr_pend = 1'b1;
            end else if (wr_pend) begin
                wr_idx  = wr_idx + 5'd1;
                wr_pend = 1'b0;
            end
            if (rd_valid) rd_q.push_back(rd_data);
            if (start) begin
                if (scl_p && scl_l && sda_p && !sda_l) starts++;
                mon_on     = 1'b1;
                nbits      = 0;
                high_seen  = 1'b0;
                last_rise  = -1;
                slave_pull = 1'b0;
            end else if (mon_on) begin
                if (scl_p && scl_l && (sda_l != sda_p) && !stop) sda_err++;
                if (!scl_p && scl_l) begin
                    if (last_rise >= 0 && (cyc - last_rise) != BIT_CLKS) period_err++;
                    last_rise = cyc;
                    high_seen = 1'b1;
                    hbit      = sda_l;
                end
                if (scl_p && !scl_l && high_seen) begin
                    bus_bits.push_back(hbit);
                    nbits++;
                    high_seen  = 1'b0;
                    slave_pull = slave_bit(nbits);
                end
                if (stop) begin
                    if (scl_p && scl_l && !sda_p && sda_l) stops++;
                    mon_on     = 1'b0;
                    slave_pull = 1'b0;
                end
            end
        end
        scl_p = ~scl_oe;
        sda_p = ~(sda_oe | slave_pull);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Transaction-level model: expected bus bits and event counts
    task automatic model(input logic [6:0] a, input logic rw, input int len,
                         input logic aack, input int nb);
        int         el;
        logic [7:0] ab;
        el = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
        ab = {a, rw};
        exp_bits.delete();
        for (int i = 7; i >= 0; i--) exp_bits.push_back(ab[i]);
        exp_bits.push_back(~aack);
        exp_nack = aack ? 0 : 1;
        exp_wr   = 0;
        exp_rd   = 0;
        if (aack) begin
            for (int k = 0; k < el; k++) begin
                for (int i = 7; i >= 0; i--) exp_bits.push_back(tx_data[k][i]);
                if (!rw) begin
                    exp_wr++;
                    exp_bits.push_back(k == nb);
                    if (k == nb) begin
                        exp_nack = 1;
                        break;
                    end
                end else begin
                    exp_rd++;
                    exp_bits.push_back(k == el - 1);
                end
            end
        end
    endtask

    task automatic launch(input logic [6:0] a, input logic rw, input int len,
                          input logic aack, input int nb);
        sl_addr_ack  = aack;
        sl_rw        = rw;
        sl_len       = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
        sl_nack_byte = nb;
        wr_idx = '0; wr_cnt = 0; starts = 0; stops = 0; period_err = 0; sda_err = 0;
        rd_q.delete();
        bus_bits.delete();
        @(negedge clk);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [6:0] a, input logic rw,
                            input int len, input logic aack, input int nb,
                            input int t_nack, input int t_wr, input int t_rd);
        int budget, mism, n;
        model(a, rw, len, aack, nb);
        launch(a, rw, len, aack, nb);
        chk({tag, " busy_on_accept"}, int'(busy), 1);
        chk({tag, " ready_low_busy"}, int'(cmd_ready), 0);
        budget = 0;
        while (!done && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, " done_seen"}, int'(done), 1);
        chk({tag, " nack"}, int'(nack), t_nack);
        @(negedge clk);
        chk({tag, " busy_after"}, int'(busy), 0);
        chk({tag, " ready_after"}, int'(cmd_ready), 1);
        chk({tag, " wr_req_count"}, wr_cnt, t_wr);
        chk({tag, " rd_count"}, rd_q.size(), t_rd);
        n = (rd_q.size() < t_rd) ? rd_q.size() : t_rd;
        for (int k = 0; k < n; k++) chk({tag, " rd_byte"}, int'(rd_q[k]), int'(tx_data[k]));
        chk({tag, " bus_bit_count"}, bus_bits.size(), exp_bits.size());
        mism = 0;
        n = (bus_bits.size() < exp_bits.size()) ? bus_bits.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (bus_bits[i] !== exp_bits[i]) mism++;
        chk({tag, " bus_bit_errors"}, mism, 0);
        chk({tag, " start_cond"}, starts, 1);
        chk({tag, " stop_cond"}, stops, 1);
        chk({tag, " scl_period_errors"}, period_err, 0);
        chk({tag, " sda_while_scl_high"}, sda_err, 0);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          len;
        logic        aack;
        int          nb;
        logic [23:0] data;
        int          e_nack;
        int          e_wr;
        int          e_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int budget;
        vecs[0] = '{7'h48, 1'b0, 2, 1'b1, 99, 24'hA53C00, 0, 2, 0};
        vecs[1] = '{7'h48, 1'b1, 2, 1'b1, 99, 24'h1BE000, 0, 0, 2};
        vecs[2] = '{7'h50, 1'b0, 0, 1'b0, 99, 24'h000000, 1, 0, 0};
        vecs[3] = '{7'h33, 1'b0, 3, 1'b1,  1, 24'h112233, 1, 2, 0};
        vecs[4] = '{7'h50, 1'b0, 0, 1'b1, 99, 24'h000000, 0, 0, 0};
        vecs[5] = '{7'h21, 1'b1, 1, 1'b1, 99, 24'h7E0000, 0, 0, 1};
        vecs[6] = '{7'h12, 1'b0, 2, 1'b0, 99, 24'hFFFF00, 1, 0, 0};
        vecs[7] = '{7'h7F, 1'b1, 0, 1'b1, 99, 24'h000000, 0, 0, 0};
        for (int i = 0; i < 32; i++) tx_data[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset scl_oe", int'(scl_oe), 0);
        chk("reset sda_oe", int'(sda_oe), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            tx_data[0] = vecs[v].data[23:16];
            tx_data[1] = vecs[v].data[15:8];
            tx_data[2] = vecs[v].data[7:0];
            run_xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rw, vecs[v].len,
                     vecs[v].aack, vecs[v].nb, vecs[v].e_nack, vecs[v].e_wr, vecs[v].e_rd);
        end

        // Length above MAX_LEN is clamped
        for (int i = 0; i < 32; i++) tx_data[i] = 8'($urandom);
        run_xfer("clamp_wr", 7'h2A, 1'b0, 20, 1'b1, 99, 0, 16, 0);
        run_xfer("clamp_rd", 7'h2B, 1'b1, 31, 1'b1, 99, 0, 0, 16);

        // Reset in the middle of a read byte
        tx_data[0] = 8'hC3;
        tx_data[1] = 8'h5A;
        launch(7'h48, 1'b1, 2, 1'b1, 99);
        budget = 0;
        while (nbits < 12 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk("midrd reached", int'(nbits >= 12), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrd scl_oe", int'(scl_oe), 0);
        chk("midrd sda_oe", int'(sda_oe), 0);
        chk("midrd cmd_ready", int'(cmd_ready), 1);
        chk("midrd busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx_data[0] = 8'h96;
        tx_data[1] = 8'h0F;
        run_xfer("after_rst", 7'h48, 1'b0, 2, 1'b1, 99, 0, 2, 0);

        // Randomized transactions against the model
        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            logic       rw, aack;
            int         len, nb;
            for (int i = 0; i < 32; i++) tx_data[i] = 8'($urandom);
            a    = 7'($urandom_range(0, 127));
            rw   = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 31))
                                               : int'($urandom_range(0, 5));
            aack = ($urandom_range(0, 9) != 0);
            nb   = int'($urandom_range(0, 6));
            model(a, rw, len, aack, nb);
            run_xfer($sformatf("rand%0d", t), a, rw, len, aack, nb, exp_nack, exp_wr, exp_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
